// File: rtl/ntt_pkg.sv
// Shared NTT geometry and per-beat tag for the zeta address generator.
// `ZETA_INTT_EN adds the inverse-transform flag to the beat tag.
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

package ntt_pkg;
    localparam int S      = `NTT_STAGE_CNT;
    localparam int BEATS  = 2 ** (S - 2);
    localparam int CNT_W  = S - 2;
    localparam int ADDR_W = S - 1;

    typedef struct packed {
        logic valid;
        logic last;
`ifdef ZETA_INTT_EN
        logic intt;
`endif
    } beat_tag_t;
endpackage

// File: rtl/zeta_addr_gen_if.sv
// Beat-stream input and zeta ROM address output bundle of zeta_addr_gen.
// `ZETA_INTT_EN adds the intt input.
interface zeta_addr_gen_if;
    import ntt_pkg::*;

    logic                          in_valid;
    logic                          in_last;
`ifdef ZETA_INTT_EN
    logic                          intt;
`endif
    logic [1:0][S-1:0][ADDR_W-1:0] rom_addr;
    logic [S-1:0]                  addr_vld;
    logic [S-1:0]                  addr_last;
    logic                          frame_err;

`ifdef ZETA_INTT_EN
    modport master (output in_valid, in_last, intt,
                    input  rom_addr, addr_vld, addr_last, frame_err);
    modport slave  (input  in_valid, in_last, intt,
                    output rom_addr, addr_vld, addr_last, frame_err);
`else
    modport master (output in_valid, in_last,
                    input  rom_addr, addr_vld, addr_last, frame_err);
    modport slave  (input  in_valid, in_last,
                    output rom_addr, addr_vld, addr_last, frame_err);
`endif
endinterface

// File: rtl/zeta_addr_stage.sv
// One NTT stage: butterfly position counter, per-lane zeta index, frame check.
// With `ZETA_INTT_EN the index order is reversed for beats tagged intt.
module zeta_addr_stage
    import ntt_pkg::*;
#(
    parameter int STAGE = 0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  beat_tag_t              tag,
    output logic [1:0][ADDR_W-1:0] addr,
    output logic                   vld,
    output logic                   last,
    output logic                   err
);
    // Shift equals ADDR_W for stage 0, which yields a constant 0 index.
    localparam int SHIFT = S - 1 - STAGE;
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'((2 ** STAGE) - 1);

    logic [CNT_W-1:0]        cnt;
    logic                    at_end;
    logic [1:0][ADDR_W-1:0]  addr_nxt;

    assign at_end = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        addr_nxt = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            addr_nxt[l] = {cnt, 1'(l)} >> SHIFT;
`ifdef ZETA_INTT_EN
            if (tag.intt) begin
                addr_nxt[l] = TOP - addr_nxt[l];
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            addr <= '0;
            vld  <= 1'b0;
            last <= 1'b0;
            err  <= 1'b0;
        end else begin
            vld  <= tag.valid;
            last <= tag.valid & tag.last;
            err  <= tag.valid & (tag.last != at_end);
            if (tag.valid) begin
                addr <= addr_nxt;
                cnt  <= (tag.last || at_end) ? '0 : cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/zeta_addr_gen.sv
// Twiddle-address generator: beat delay line feeding one zeta_addr_stage per NTT stage.
// `ZETA_INTT_EN carries a per-beat inverse-transform flag through the delay line.
module zeta_addr_gen
    import ntt_pkg::*;
#(
    parameter int STAGE_LAT = 3
)
(
    input  logic           clk,
    input  logic           rst_n,
    zeta_addr_gen_if.slave bus
);
    localparam int DEPTH = (S - 1) * STAGE_LAT;

    beat_tag_t                     in_tag;
    beat_tag_t [DEPTH-1:0]         dly;
    beat_tag_t [S-1:0]             tap;
    logic [S-1:0][1:0][ADDR_W-1:0] stage_addr;
    logic [S-1:0]                  stage_vld;
    logic [S-1:0]                  stage_last;
    logic [S-1:0]                  stage_err;

    always_comb begin
        in_tag       = '0;
        in_tag.valid = bus.in_valid;
        in_tag.last  = bus.in_last;
`ifdef ZETA_INTT_EN
        in_tag.intt  = bus.intt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly <= {dly[DEPTH-2:0], in_tag};
        end
    end

    // Tap i sees the beat i*STAGE_LAT cycles after stage 0.
    assign tap[0] = in_tag;
    for (genvar i = 1; i < S; i++) begin : g_tap
        assign tap[i] = dly[i*STAGE_LAT-1];
    end

    for (genvar i = 0; i < S; i++) begin : g_stage
        zeta_addr_stage #(.STAGE(i)) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .tag  (tap[i]),
            .addr (stage_addr[i]),
            .vld  (stage_vld[i]),
            .last (stage_last[i]),
            .err  (stage_err[i])
        );
    end

    always_comb begin
        bus.rom_addr = '0;
        for (int unsigned s = 0; s < S; s++) begin
            for (int unsigned l = 0; l < 2; l++) begin
                bus.rom_addr[l][s] = stage_addr[s][l];
            end
        end
    end

    assign bus.addr_vld  = stage_vld;
    assign bus.addr_last = stage_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_err <= 1'b0;
        end else if (|stage_err) begin
            bus.frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_zeta_addr_gen.sv
// Directed bench for zeta_addr_gen (S=8, STAGE_LAT=3); intt scenario needs `ZETA_INTT_EN.
module tb_zeta_addr_gen;
    import ntt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zeta_addr_gen_if bus ();
    zeta_addr_gen #(.STAGE_LAT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int   cyc;
        int   a0;
        int   a1;
        logic last;
    } cap_t;

    cap_t cap [S][$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
`ifdef ZETA_INTT_EN
    logic next_intt = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid stage address with the cycle it was observed in.
    always @(negedge clk) begin
        for (int s = 0; s < S; s++) begin
            if (bus.addr_vld[s] === 1'b1)
                cap[s].push_back('{cyc, int'(bus.rom_addr[0][s]), int'(bus.rom_addr[1][s]),
                                   bus.addr_last[s]});
        end
    end

    task automatic clear_caps();
        for (int s = 0; s < S; s++) cap[s].delete();
    endtask

    task automatic send(input logic l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_last  = l;
`ifdef ZETA_INTT_EN
        bus.intt     = next_intt;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (bus.addr_vld !== '0) begin errors++; $display("FAIL reset_vld: got %h want 0", bus.addr_vld); end
        checks++;
        if (bus.addr_last !== '0) begin errors++; $display("FAIL reset_last: got %h want 0", bus.addr_last); end
        checks++;
        if (bus.rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.rom_addr); end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
        rst_n = 1'b1;
        clear_caps();
        idle(5);
        checks++;
        if (cap[0].size() != 0) begin errors++; $display("FAIL reset_idle: got %0d beats want 0", cap[0].size()); end
    endtask

    task automatic test_contiguous();
        int c0 = 0;
        clear_caps();
        for (int n = 0; n < 64; n++) begin
            send(n == 63);
            if (n == 0) c0 = cyc;
        end
        idle(30);
        for (int s = 0; s < S; s++) begin
            checks++;
            if (cap[s].size() != 64) begin
                errors++; $display("FAIL contig_count s%0d: got %0d want 64", s, cap[s].size());
            end else begin
                checks++;
                if (cap[s][0].cyc != c0 + 3*s + 1) begin
                    errors++; $display("FAIL contig_first s%0d: got %0d want %0d", s, cap[s][0].cyc - c0, 3*s + 1);
                end
                for (int n = 0; n < 64; n++) begin
                    checks++;
                    if (cap[s][n].a0 != ((2*n) >> (7-s)) || cap[s][n].a1 != ((2*n+1) >> (7-s))
                        || cap[s][n].last !== (n == 63)) begin
                        errors++; $display("FAIL contig_addr s%0d n%0d: got %0d,%0d,%b want %0d,%0d,%b", s, n,
                            cap[s][n].a0, cap[s][n].a1, cap[s][n].last, (2*n) >> (7-s), (2*n+1) >> (7-s), n == 63);
                    end
                end
            end
        end
        if (cap[7].size() == 64) begin
            checks++;
            if (cap[7][63].cyc != c0 + 85) begin errors++; $display("FAIL contig_end: got %0d want 85", cap[7][63].cyc - c0); end
        end
        if (cap[1].size() == 64) begin
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (cap[1][n].a0 != (n < 32 ? 0 : 1)) begin
                    errors++; $display("FAIL contig_s1 n%0d: got %0d want %0d", n, cap[1][n].a0, n < 32 ? 0 : 1);
                end
            end
        end
        checks++;
        if (bus.rom_addr[0][7] !== 7'd126 || bus.rom_addr[1][7] !== 7'd127) begin
            errors++; $display("FAIL idle_hold: got %0d,%0d want 126,127", bus.rom_addr[0][7], bus.rom_addr[1][7]);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL contig_err: got %b want 0", bus.frame_err); end
    endtask

    task automatic test_gaps();
        int c0 = 0;
        clear_caps();
        for (int n = 0; n < 64; n++) begin
            send(n == 63);
            if (n == 0) c0 = cyc;
            idle(1);
        end
        idle(30);
        for (int s = 0; s < S; s++) begin
            checks++;
            if (cap[s].size() != 64) begin
                errors++; $display("FAIL gap_count s%0d: got %0d want 64", s, cap[s].size());
            end else begin
                for (int n = 0; n < 64; n++) begin
                    checks++;
                    if (cap[s][n].a0 != ((2*n) >> (7-s)) || cap[s][n].a1 != ((2*n+1) >> (7-s))
                        || cap[s][n].cyc != c0 + 3*s + 1 + 2*n) begin
                        errors++; $display("FAIL gap_addr s%0d n%0d: got %0d,%0d @%0d want %0d,%0d @%0d", s, n,
                            cap[s][n].a0, cap[s][n].a1, cap[s][n].cyc - c0, (2*n) >> (7-s), (2*n+1) >> (7-s), 3*s + 1 + 2*n);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        for (int n = 0; n < 128; n++) send(n == 63 || n == 127);
        idle(30);
        checks++;
        if (cap[7].size() != 128) begin
            errors++; $display("FAIL b2b_count: got %0d want 128", cap[7].size());
        end else begin
            checks++;
            if (cap[7][64].cyc != cap[7][63].cyc + 1) begin
                errors++; $display("FAIL b2b_bubble: got gap %0d want 1", cap[7][64].cyc - cap[7][63].cyc);
            end
            for (int n = 0; n < 128; n++) begin
                checks++;
                if (cap[7][n].a0 != 2*(n%64) || cap[7][n].a1 != 2*(n%64) + 1
                    || cap[7][n].last !== (n == 63 || n == 127)) begin
                    errors++; $display("FAIL b2b_addr n%0d: got %0d,%0d,%b want %0d,%0d", n,
                        cap[7][n].a0, cap[7][n].a1, cap[7][n].last, 2*(n%64), 2*(n%64) + 1);
                end
            end
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b want 0", bus.frame_err); end
    endtask

    task automatic test_bad_last();
        int c0 = 0;
        clear_caps();
        // 41-beat frame with early last, then 65 beats with no last at all.
        for (int k = 0; k < 106; k++) begin
            send(k == 40);
            if (k == 0) c0 = cyc;
            if (k == 41) begin
                checks++;
                if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", bus.frame_err); end
            end
            if (k == 42) begin
                checks++;
                if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus.frame_err); end
            end
        end
        idle(30);
        checks++;
        if (cap[7].size() != 106) begin
            errors++; $display("FAIL bad_count: got %0d want 106", cap[7].size());
        end else begin
            checks++;
            if (cap[7][40].a0 != 80 || cap[7][40].last !== 1'b1) begin
                errors++; $display("FAIL bad_last: got %0d,%b want 80,1", cap[7][40].a0, cap[7][40].last);
            end
            checks++;
            if (cap[7][41].a0 != 0 || cap[7][41].a1 != 1) begin
                errors++; $display("FAIL bad_restart: got %0d,%0d want 0,1", cap[7][41].a0, cap[7][41].a1);
            end
            checks++;
            if (cap[7][104].a0 != 126 || cap[7][104].a1 != 127) begin
                errors++; $display("FAIL bad_top: got %0d,%0d want 126,127", cap[7][104].a0, cap[7][104].a1);
            end
            checks++;
            if (cap[7][105].a0 != 0 || cap[7][105].a1 != 1) begin
                errors++; $display("FAIL bad_wrap: got %0d,%0d want 0,1", cap[7][105].a0, cap[7][105].a1);
            end
        end
        if (cap[1].size() == 106) begin
            checks++;
            if (cap[1][73].a0 != 1 || cap[1][105].a0 != 0) begin
                errors++; $display("FAIL bad_s1: got %0d,%0d want 1,0", cap[1][73].a0, cap[1][105].a0);
            end
        end
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.frame_err); end
    endtask

    task automatic test_reset_mid();
        int c0 = 0;
        clear_caps();
        for (int n = 0; n < 30; n++) send(1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.addr_vld !== '0 || bus.addr_last !== '0 || bus.rom_addr !== '0 || bus.frame_err !== 1'b0) begin
            errors++; $display("FAIL async_reset: got vld=%h last=%h addr=%h err=%b want all 0",
                bus.addr_vld, bus.addr_last, bus.rom_addr, bus.frame_err);
        end
        bus.in_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        clear_caps();
        idle(30);
        checks++;
        if (cap[0].size() + cap[4].size() + cap[7].size() != 0) begin
            errors++; $display("FAIL reset_flush: got %0d stale beats want 0", cap[0].size() + cap[4].size() + cap[7].size());
        end
        for (int n = 0; n < 64; n++) begin
            send(n == 63);
            if (n == 0) c0 = cyc;
        end
        idle(30);
        checks++;
        if (cap[7].size() != 64 || cap[7][0].cyc != c0 + 22) begin
            errors++; $display("FAIL fresh_frame: got %0d beats want 64 from cycle 22", cap[7].size());
        end else begin
            for (int n = 0; n < 64; n++) begin
                checks++;
                if (cap[7][n].a0 != 2*n || cap[7][n].a1 != 2*n + 1) begin
                    errors++; $display("FAIL fresh_addr n%0d: got %0d,%0d want %0d,%0d", n,
                        cap[7][n].a0, cap[7][n].a1, 2*n, 2*n + 1);
                end
            end
        end
    endtask

`ifdef ZETA_INTT_EN
    task automatic test_intt();
        int e0;
        int e1;
        clear_caps();
        next_intt = 1'b1;
        for (int n = 0; n < 64; n++) send(n == 63);
        next_intt = 1'b0;
        for (int n = 0; n < 64; n++) send(n == 63);
        idle(30);
        for (int s = 0; s < S; s++) begin
            checks++;
            if (cap[s].size() != 128) begin
                errors++; $display("FAIL intt_count s%0d: got %0d want 128", s, cap[s].size());
            end else begin
                for (int n = 0; n < 128; n++) begin
                    e0 = (2*(n%64)) >> (7-s);
                    e1 = (2*(n%64)+1) >> (7-s);
                    if (n < 64) begin
                        e0 = (2**s - 1) - e0;
                        e1 = (2**s - 1) - e1;
                    end
                    checks++;
                    if (cap[s][n].a0 != e0 || cap[s][n].a1 != e1) begin
                        errors++; $display("FAIL intt_addr s%0d n%0d: got %0d,%0d want %0d,%0d", s, n,
                            cap[s][n].a0, cap[s][n].a1, e0, e1);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
`ifdef ZETA_INTT_EN
        bus.intt     = 1'b0;
`endif
        test_reset();
        test_contiguous();
        test_gaps();
        test_back_to_back();
        test_bad_last();
        test_reset_mid();
`ifdef ZETA_INTT_EN
        test_intt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
